// File: rtl/aidc_lite_pkg.sv
// aidc_lite_pkg: shared AHB encodings and read-engine state type for AIDC-Lite.
package aidc_lite_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam int BURST_BYTES = 16;
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA, S_DONE} rd_state_t;
endpackage

// File: rtl/aidc_lite_sync_fifo.sv
// aidc_lite_sync_fifo: single-clock FIFO exposing its occupancy; pop on empty is ignored.
module aidc_lite_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic pop;

    always_comb begin
        pop    = pop_i && cnt_q != '0;
        wptr_d = push_i ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
        cnt_d  = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = cnt_q != '0 ? mem_q[rptr_q] : '0;
    assign count_o = cnt_q;
endmodule

// File: rtl/aidc_lite_ahb_rd_engine.sv
// aidc_lite_ahb_rd_engine: AHB INCR4 source fetch feeding the compressor through a FIFO.
// Define AIDC_LITE_RD_STALL_CNT_EN to add the saturating hready-low stall counter.
module aidc_lite_ahb_rd_engine
    import aidc_lite_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int BURST_LEN  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [31:0]       byte_len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] haddr_o,
    output logic [1:0]        htrans_o,
    output logic              hwrite_o,
    output logic [2:0]        hsize_o,
    output logic [2:0]        hburst_o,
    input  logic              hready_i,
    input  logic              hresp_i,
    input  logic [DATA_W-1:0] hrdata_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              rd_ready_i,
    output logic [31:0]       stall_cnt_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(BURST_LEN);

    rd_state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [29:0] beats_q, beats_d;
    logic [BW-1:0] abeat_q, abeat_d;
    logic dvalid_q, dvalid_d, err_q, err_d;
    logic start_ok, acc, hit_err, push, room;
    logic [CW-1:0] fifo_cnt;
    logic unused_bits;

    assign unused_bits = ^{byte_len_i[3:0], src_addr_i[3:0]};
    // Outstanding beats are always zero in S_WAIT, so occupancy alone sizes the reservation.
    assign room    = int'(fifo_cnt) + BURST_LEN <= FIFO_DEPTH;
    assign hit_err = dvalid_q && hresp_i;
    assign push    = dvalid_q && hready_i && !hresp_i;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        beats_d  = beats_q;
        abeat_d  = abeat_q;
        err_d    = err_q;
        start_ok = 1'b0;
        htrans_o = HTRANS_IDLE;
        hburst_o = 3'b000;
        case (state_q)
            S_IDLE: if (start_i) begin
                start_ok = 1'b1;
                state_d  = S_WAIT;
                addr_d   = {src_addr_i[ADDR_W-1:4], 4'h0};
                beats_d  = {byte_len_i[31:4], 2'b00};
                err_d    = 1'b0;
            end
            S_WAIT: if (beats_q == '0) state_d = S_DONE;
                    else if (room) begin
                        state_d = S_ADDR;
                        abeat_d = '0;
                    end
            S_ADDR: begin
                hburst_o = HBURST_INCR4;
                // First ERROR cycle must cancel the pending address phase.
                htrans_o = hit_err ? HTRANS_IDLE : (abeat_q == '0 ? HTRANS_NONSEQ : HTRANS_SEQ);
            end
            S_DATA: if (dvalid_q && hready_i) state_d = S_WAIT;
            S_DONE: if (fifo_cnt == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        acc = htrans_o != HTRANS_IDLE && hready_i;
        if (acc) begin
            addr_d  = addr_q + ADDR_W'(DATA_W/8);
            abeat_d = abeat_q + 1'b1;
            if (abeat_q == BW'(BURST_LEN-1)) begin
                state_d = S_DATA;
                beats_d = beats_q - 30'(BURST_LEN);
            end
        end
        if (hit_err) begin
            err_d   = 1'b1;
            state_d = S_DONE;
        end
        dvalid_d = hit_err ? 1'b0 : (hready_i ? acc : dvalid_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            beats_q  <= '0;
            abeat_q  <= '0;
            dvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            beats_q  <= beats_d;
            abeat_q  <= abeat_d;
            dvalid_q <= dvalid_d;
            err_q    <= err_d;
        end
    end

    aidc_lite_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (hrdata_i),
        .pop_i   (rd_ready_i),
        .data_o  (rd_data_o),
        .count_o (fifo_cnt)
    );

    assign rd_valid_o = fifo_cnt != '0;
    assign done_o     = state_q == S_DONE && fifo_cnt == '0;
    assign busy_o     = state_q != S_IDLE;
    assign err_o      = err_q;
    assign haddr_o    = addr_q;
    assign hwrite_o   = 1'b0;
    assign hsize_o    = HSIZE_WORD;

`ifdef AIDC_LITE_RD_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;
    always_comb begin
        stall_d = stall_q;
        if (start_ok) stall_d = '0;
        else if (busy_o && !hready_i && stall_q != '1) stall_d = stall_q + 32'd1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else stall_q <= stall_d;
    end
    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif
endmodule
